bar_frame_writer: RTL

//  Writer side of the panel frame buffer. The display path reads this buffer
//  one row-pair per address (row r and row r+32, 64 px each).
//  - Accepts one frame of per-column bar heights on a valid/ready stream.
//  - Renders the heights into 32 double-row words and writes them into the

---
 rtl/display_pkg.sv | 26 ++
 rtl/bar_row_render.sv | 25 ++
 rtl/bar_frame_writer.sv | 104 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, state encoding and height saturation for the panel
// frame-buffer writer.
package display_pkg;

  localparam int NUM_COLS   = 64;
  localparam int NUM_ROWS   = 64;
  localparam int HALF_ROWS  = 32;
  localparam int MAX_HEIGHT = 64;
  localparam int HEIGHT_W   = 7;
  localparam int ADDR_W     = 5;
  localparam int COL_W      = 6;
  localparam int ROW_W      = 6;

  typedef enum logic [1:0] {
    COLLECT,
    RENDER,
    WAIT_SWAP
  } frame_writer_state_t;

  typedef logic [NUM_COLS-1:0][HEIGHT_W-1:0] height_array_t;

  function automatic logic [HEIGHT_W-1:0] sat_height(input logic [HEIGHT_W-1:0] h);
    return (h > HEIGHT_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT) : h;
  endfunction

endpackage

// File: rtl/bar_row_render.sv
// Combinational renderer: one panel row of lit/dark pixels from the column
// heights. Bars grow upward from the bottom row, so row r is lit when h+r>=64.
module bar_row_render
  import display_pkg::*;
(
  input  logic                heights_in_unused_guard,
  input  height_array_t       heights,
  input  logic [ROW_W-1:0]    row,
  output logic [NUM_COLS-1:0] pixels
);

  localparam logic [HEIGHT_W:0] THRESHOLD = (HEIGHT_W+1)'(NUM_ROWS);

  logic [HEIGHT_W:0] row_ext;
  assign row_ext = (HEIGHT_W+1)'(row);

  // Extra sum bit keeps 7-bit height + 6-bit row from wrapping.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign pixels[c] = ({1'b0, heights[c]} + row_ext) >= THRESHOLD;
  end

  logic unused;
  assign unused = heights_in_unused_guard;

endmodule

// File: rtl/bar_frame_writer.sv
// Writer side of the double-banked panel frame buffer: collects bar heights,
// renders 32 row-pair words into the back bank, swaps on display end-of-frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// COLLECT   | accepting height beats, bar_ready high
// RENDER    | stepping row_cnt 0..31, one registered write per cycle
// WAIT_SWAP | frame complete, waiting for frame_done with writes drained
module bar_frame_writer
  import display_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                bar_valid,
  output logic                bar_ready,
  input  logic [HEIGHT_W-1:0] bar_height,
  input  logic                bar_last,
  input  logic                frame_done,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_COLS-1:0] wr_row_0,
  output logic [NUM_COLS-1:0] wr_row_1,
  output logic                disp_bank,
  output logic                frame_swapped
);

  frame_writer_state_t state, state_next;
  logic [COL_W-1:0]    col_cnt;
  logic [ADDR_W-1:0]   row_cnt;
  height_array_t       heights;
  logic                beat, beat_end, render, swap;
  logic [NUM_COLS-1:0] pix_0, pix_1;

  assign beat     = bar_valid & bar_ready;
  assign beat_end = beat & (bar_last | (col_cnt == COL_W'(NUM_COLS-1)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RENDER;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT:   if (beat_end) state_next = RENDER;
      RENDER:    if (row_cnt == ADDR_W'(HALF_ROWS-1)) state_next = WAIT_SWAP;
      WAIT_SWAP: if (frame_done && !wr_en) state_next = COLLECT;
      default:   state_next = RENDER;
    endcase
  end

  // The last write is still in flight during the first WAIT_SWAP cycle.
  always_comb begin
    bar_ready = (state == COLLECT);
    render    = (state == RENDER);
    swap      = (state == WAIT_SWAP) && frame_done && !wr_en;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_cnt       <= '0;
      row_cnt       <= '0;
      heights       <= '0;
      disp_bank     <= 1'b0;
      frame_swapped <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_row_0      <= '0;
      wr_row_1      <= '0;
    end else begin
      if (beat) begin
        heights[col_cnt] <= sat_height(bar_height);
        col_cnt          <= beat_end ? '0 : col_cnt + COL_W'(1);
      end
      if (render) begin
        row_cnt  <= row_cnt + ADDR_W'(1);
        wr_addr  <= row_cnt;
        wr_row_0 <= pix_0;
        wr_row_1 <= pix_1;
      end
      wr_en         <= render;
      frame_swapped <= swap;
      if (swap) disp_bank <= ~disp_bank;
    end
  end

  assign wr_bank = ~disp_bank;

  bar_row_render u_render_0 (
    .heights_in_unused_guard (1'b0),
    .heights                 (heights),
    .row                     ({1'b0, row_cnt}),
    .pixels                  (pix_0)
  );

  bar_row_render u_render_1 (
    .heights_in_unused_guard (1'b0),
    .heights                 (heights),
    .row                     ({1'b1, row_cnt}),
    .pixels                  (pix_1)
  );

endmodule
